// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side adapters.
//   FIFO_RD_LAT : read latency of sync_fifo (rd_en in cycle N, rd_data valid in N+1)
//   clog2_min1  : counter width for a modulus n, never narrower than one bit
package fifo_pkg;

    localparam int unsigned FIFO_RD_LAT = 1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/tail output buffer for a valid/ready stream.
//   clk, rst   : clock, asynchronous active-low reset
//   wr_en      : write strobe (caller guarantees space)
//   wr_data    : word to store
//   pop        : consumer takes the head word this cycle
//   head_data  : current head word (drives the stream data)
//   level      : number of stored words, 0..2
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        level
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        level_q, level_d;
    logic              pop_eff;
    logic              wr_to_head;

    always_comb begin
        pop_eff    = pop & (level_q != 2'd0);
        // New word lands in head when head is free after this cycle's pop.
        wr_to_head = (level_q == 2'd0) || (pop_eff && (level_q == 2'd1));
        head_d     = head_q;
        tail_d     = tail_q;
        if (pop_eff && (level_q == 2'd2)) begin
            head_d = tail_q;
        end
        if (wr_en) begin
            if (wr_to_head) begin
                head_d = wr_data;
            end else begin
                tail_d = wr_data;
            end
        end
        level_d = level_q + {1'b0, wr_en} - {1'b0, pop_eff};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    assign head_data = head_q;
    assign level     = level_q;

endmodule

// File: rtl/sync_fifo_reader.sv
// First-word-fall-through read adapter for sync_fifo, with fixed-length burst framing.
//   clk, rst      : clock, asynchronous active-low reset
//   fifo_rd_data  : FIFO read data, one cycle after an accepted fifo_rd_en
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : FIFO pop request
//   out_data      : stream data (head of output buffer)
//   out_valid     : stream valid
//   out_ready     : stream ready from consumer
//   out_last      : final beat of the current burst
//   buf_level     : words held in the output buffer, excluding an in-flight read
module sync_fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [1:0]        buf_level
);

    localparam int unsigned     CNT_W     = clog2_min1(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic             inflight_q;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             pop;
    logic [2:0]       credit;

    stream_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (inflight_q),
        .wr_data   (fifo_rd_data),
        .pop       (pop),
        .head_data (out_data),
        .level     (buf_level)
    );

    always_comb begin
        out_valid = (buf_level != 2'd0);
        out_last  = out_valid & (beat_cnt_q == LAST_BEAT);
        pop       = out_valid & out_ready;
        // Slots committed after this cycle: stored words plus the returning read, less a pop.
        // pop implies buf_level >= 1, so this never underflows.
        credit     = {1'b0, buf_level} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !fifo_empty && (credit < 3'd2);
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = out_last ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
module tb_sync_fifo_reader;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BURST_LEN = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [1:0]        buf_level;

    sync_fifo_reader #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .buf_level    (buf_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sync_fifo: registered read port, one-cycle latency, unbounded depth.
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] fifo_mem[$];
    int                fifo_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_mem.delete();
            fifo_cnt     <= 0;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_rd_en && fifo_mem.size() > 0) fifo_rd_data <= fifo_mem.pop_front();
            if (wr_req) fifo_mem.push_back(wr_data);
            fifo_cnt <= fifo_mem.size();
        end
    end
    assign fifo_empty = (fifo_cnt == 0);

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_w;
    int                exp_beat = 0;
    logic              exp_last;

    logic              obs_valid, obs_last, obs_rden, obs_empty, obs_pop;
    logic [DATA_W-1:0] obs_data;
    logic [1:0]        obs_level;

    // Drive one cycle of stimulus at the falling edge, then sample outputs.
    task automatic tick(input logic wr, input logic [DATA_W-1:0] wd, input logic rdy);
        @(negedge clk);
        wr_req    = wr;
        wr_data   = wd;
        out_ready = rdy;
        if (wr) exp_q.push_back(wd);
        #1;
        obs_valid = out_valid;
        obs_last  = out_last;
        obs_data  = out_data;
        obs_level = buf_level;
        obs_rden  = fifo_rd_en;
        obs_empty = fifo_empty;
        obs_pop   = out_valid & rdy;
        exp_last  = out_valid && (exp_beat == BURST_LEN - 1);
    endtask

    task automatic model_step();
        if (obs_pop) exp_beat = (exp_beat == BURST_LEN - 1) ? 0 : exp_beat + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        wr_req = 1'b0;
        exp_q.delete();
        exp_beat = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, expected 0", out_last); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %02h, expected 00", out_data); end
        checks++; if (buf_level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", buf_level); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b, expected 0", fifo_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, '0, 1'b1);
        checks++; if (obs_valid !== 1'b0 || obs_rden !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: valid=%b rden=%b, expected 0 0", obs_valid, obs_rden);
        end
    endtask

    task automatic test_first_words();
        int t_empty = -1, t_valid = -1, npop = 0, first_pop = -1, last_pop = -1, nlast = 0;
        logic rden_at_empty = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(i < 4, DATA_W'(i + 1), 1'b1);
            if (t_empty < 0 && !obs_empty) begin t_empty = i; rden_at_empty = obs_rden; end
            if (t_valid < 0 && obs_valid) t_valid = i;
            checks++; if (obs_last !== exp_last) begin errors++; $display("FAIL first_last: cycle %0d got %b, expected %b", i, obs_last, exp_last); end
            if (obs_last) nlast++;
            if (obs_pop) begin
                npop++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL first_data: popped %02h, expected no word", obs_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (obs_data !== exp_w) begin errors++; $display("FAIL first_data: got %02h, expected %02h", obs_data, exp_w); end
                end
            end
            model_step();
        end
        checks++; if (t_empty < 0 || t_valid - t_empty != 2) begin errors++; $display("FAIL first_latency: got %0d cycles, expected 2", t_valid - t_empty); end
        checks++; if (rden_at_empty !== 1'b1) begin errors++; $display("FAIL first_rden: got %b, expected 1", rden_at_empty); end
        checks++; if (npop != 4 || last_pop - first_pop != 3) begin
            errors++; $display("FAIL first_consecutive: got %0d pops over span %0d, expected 4 over 3", npop, last_pop - first_pop);
        end
        checks++; if (nlast != 0) begin errors++; $display("FAIL first_no_last: got %0d, expected 0", nlast); end
    endtask

    task automatic test_stream48();
        int npop = 0, nlast = 0, gaps = 0, i = 0;
        do_reset();
        while ((i < 48 || npop < 48) && i < 200) begin
            tick(i < 48, DATA_W'(i * 3 + 7), 1'b1);
            checks++; if (obs_last !== exp_last) begin errors++; $display("FAIL s48_last: pop %0d got %b, expected %b", npop, obs_last, exp_last); end
            if (npop > 0 && npop < 48 && !obs_pop) gaps++;
            if (obs_pop) begin
                if (obs_last) nlast++;
                npop++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL s48_data: popped %02h, expected no word", obs_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (obs_data !== exp_w) begin errors++; $display("FAIL s48_data: got %02h, expected %02h", obs_data, exp_w); end
                end
            end
            model_step();
            i++;
        end
        checks++; if (npop != 48) begin errors++; $display("FAIL s48_count: got %0d, expected 48", npop); end
        checks++; if (nlast != 3) begin errors++; $display("FAIL s48_nlast: got %0d, expected 3", nlast); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL s48_bubbles: got %0d, expected 0", gaps); end
    endtask

    task automatic test_backpressure();
        int npop = 0, max_level = 0;
        logic stalled;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            stalled = (i >= 4 && i < 9);
            tick(i < 8, DATA_W'(8'h40 + i), !stalled);
            if (int'(obs_level) > max_level) max_level = int'(obs_level);
            if (i == 3) begin
                checks++; if (obs_rden !== 1'b1) begin errors++; $display("FAIL bp_pre_rden: got %b, expected 1", obs_rden); end
            end
            if (stalled) begin
                checks++; if (obs_rden !== 1'b0) begin errors++; $display("FAIL bp_stall_rden: cycle %0d got %b, expected 0", i, obs_rden); end
            end
            if (i == 9) begin
                checks++; if (obs_rden !== 1'b1) begin errors++; $display("FAIL bp_resume_rden: got %b, expected 1", obs_rden); end
            end
            if (obs_pop) begin
                npop++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_data: popped %02h, expected no word", obs_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (obs_data !== exp_w) begin errors++; $display("FAIL bp_data: got %02h, expected %02h", obs_data, exp_w); end
                end
            end
            model_step();
        end
        checks++; if (max_level != 2) begin errors++; $display("FAIL bp_level: got %0d, expected 2", max_level); end
        checks++; if (npop != 8) begin errors++; $display("FAIL bp_count: got %0d, expected 8", npop); end
    endtask

    task automatic test_random();
        int n_wr = 0, cyc = 0, bad_level = 0, bad_stable = 0;
        logic              p_hold = 1'b0, p_last = 1'b0;
        logic [DATA_W-1:0] p_data = '0;
        logic              w;
        do_reset();
        while ((n_wr < 10000 || exp_q.size() != 0) && cyc < 60000) begin
            w = (n_wr < 10000) && ($urandom_range(0, 99) < 55);
            tick(w, DATA_W'($urandom), 1'($urandom_range(0, 1)));
            if (w) n_wr++;
            checks++; if (obs_level > 2'd2) begin bad_level++; errors++; $display("FAIL rnd_level: got %0d, expected <=2", obs_level); end
            checks++; if (obs_last !== exp_last) begin errors++; $display("FAIL rnd_last: got %b, expected %b", obs_last, exp_last); end
            if (p_hold) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_data !== p_data || obs_last !== p_last) begin
                    bad_stable++; errors++;
                    $display("FAIL rnd_stable: got v=%b d=%02h l=%b, expected v=1 d=%02h l=%b", obs_valid, obs_data, obs_last, p_data, p_last);
                end
            end
            p_hold = obs_valid && !obs_pop;
            p_data = obs_data;
            p_last = obs_last;
            if (obs_pop) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_data: popped %02h, expected no word", obs_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (obs_data !== exp_w) begin errors++; $display("FAIL rnd_data: got %02h, expected %02h", obs_data, exp_w); end
                end
            end
            model_step();
            cyc++;
        end
        checks++; if (exp_q.size() != 0 || n_wr != 10000) begin
            errors++; $display("FAIL rnd_drain: got %0d words left of %0d written, expected 0 of 10000", exp_q.size(), n_wr);
        end
    endtask

    task automatic test_dry();
        int npop = 0, last_idx = -1, nlast = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(i < 6, DATA_W'(8'h80 + i), 1'b1);
            if (obs_pop) begin
                npop++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL dry_data: popped %02h, expected no word", obs_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (obs_data !== exp_w) begin errors++; $display("FAIL dry_data: got %02h, expected %02h", obs_data, exp_w); end
                end
            end
            model_step();
        end
        checks++; if (npop != 6 || obs_valid !== 1'b0) begin errors++; $display("FAIL dry_drain: got %0d pops valid=%b, expected 6 valid=0", npop, obs_valid); end
        checks++; if (dut.beat_cnt_q !== 4'd6) begin errors++; $display("FAIL dry_hold: got beat %0d, expected 6", dut.beat_cnt_q); end
        npop = 0;
        for (int i = 0; i < 30; i++) begin
            tick(i < 10, DATA_W'(8'h90 + i), 1'b1);
            checks++; if (obs_last !== exp_last) begin errors++; $display("FAIL dry_last: got %b, expected %b", obs_last, exp_last); end
            if (obs_pop) begin
                if (obs_last) begin nlast++; last_idx = npop; end
                npop++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL dry_resume_data: popped %02h, expected no word", obs_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (obs_data !== exp_w) begin errors++; $display("FAIL dry_resume_data: got %02h, expected %02h", obs_data, exp_w); end
                end
            end
            model_step();
        end
        checks++; if (nlast != 1 || last_idx != 9) begin errors++; $display("FAIL dry_last_pos: got %0d lasts at %0d, expected 1 at 9", nlast, last_idx); end
        checks++; if (dut.beat_cnt_q !== 4'd0) begin errors++; $display("FAIL dry_wrap: got beat %0d, expected 0", dut.beat_cnt_q); end
    endtask

    task automatic test_reset_midop();
        int npop = 0;
        do_reset();
        for (int i = 0; i < 8; i++) tick(i < 6, DATA_W'(8'hC0 + i), 1'b0);
        checks++; if (obs_level !== 2'd2) begin errors++; $display("FAIL mid_pre_level: got %0d, expected 2", obs_level); end
        @(negedge clk);
        wr_req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_data: got %02h, expected 00", out_data); end
        checks++; if (buf_level !== 2'd0) begin errors++; $display("FAIL mid_level: got %0d, expected 0", buf_level); end
        checks++; if (fifo_rd_en !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("FAIL mid_rden_last: got %b %b, expected 0 0", fifo_rd_en, out_last);
        end
        checks++; if (dut.inflight_q !== 1'b0) begin errors++; $display("FAIL mid_inflight: got %b, expected 0", dut.inflight_q); end
        exp_q.delete();
        exp_beat = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(i < 2, (i == 0) ? DATA_W'(8'hA5) : DATA_W'(8'h5A), 1'b1);
            if (obs_pop) begin
                npop++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL mid_after_data: popped %02h, expected no word", obs_data); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (obs_data !== exp_w) begin errors++; $display("FAIL mid_after_data: got %02h, expected %02h", obs_data, exp_w); end
                end
            end
            model_step();
        end
        checks++; if (npop != 2) begin errors++; $display("FAIL mid_after_count: got %0d, expected 2", npop); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        wr_req    = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_first_words();
        test_stream48();
        test_backpressure();
        test_random();
        test_dry();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_reader.md
# sync_fifo_reader

Read-side adapter for the team's synchronous FIFO. Converts the FIFO's registered read port (rd_en / rd_data with one-cycle latency, empty flag) into a first-word-fall-through valid/ready stream. Sustains one word per cycle, tolerates downstream back-pressure without losing in-flight data, and frames the stream into fixed-length bursts with a `last` marker. Sits between a `sync_fifo` instance and any compute or DMA consumer.

## Interface
- DATA_W, 8, word width; must match the FIFO's DATA_W
- BURST_LEN, 16, beats per burst; `out_last` marks beat BURST_LEN-1; legal range 1..65536
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after an accepted `fifo_rd_en`
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer
- out_last  out  1  final beat of the current burst
- buf_level  out  2  words held in the output buffer (0..2), excluding the in-flight read

## Operation
- The output buffer is 2 entries. `head` drives `out_data`/`out_last`. `tail` is used only when back-pressure lands while a read is in flight.
- pop = out_valid & out_ready.
- inflight = 1 in the cycle after `fifo_rd_en` was asserted.
- fifo_rd_en = !fifo_empty & (buf_level + inflight - pop < 2). This is combinational from `fifo_empty`, `out_ready` and registered state. It never over-commits buffer space.
- Returning data is written to `head` if the buffer is empty or if `head` is popped that cycle with no `tail`. Otherwise it is written to `tail`. On a pop with `tail` valid, `tail` moves to `head`.
- out_valid = (buf_level != 0).
- Stream rule: once `out_valid` is high, `out_data` and `out_last` hold until the pop.
- Burst counter, beat_cnt, 0..BURST_LEN-1:
  - Increments on each pop.
  - Wraps to 0 on the pop where out_last = 1.
  - out_last = out_valid & (beat_cnt == BURST_LEN-1).
  - With BURST_LEN = 1, `out_last` is high on every beat.
- Counter width is clog2(BURST_LEN), minimum 1. Comparisons are done at that width.
- If the FIFO goes empty mid-burst, `out_valid` drops and `beat_cnt` holds. The burst resumes when data returns; no padding is inserted.

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_last=0, out_data=0, buf_level=0, beat_cnt=0, inflight=0.
- Latency: `fifo_empty` falls in cycle N → `fifo_rd_en` high in N → data captured at the end of N+1 → `out_valid` high in N+2.
- Throughput: with the FIFO non-empty and `out_ready` held high, one pop per cycle indefinitely.
- Back-pressure: `out_ready` low with a read in flight → the word lands in `tail`, buf_level=2, and `fifo_rd_en` stays low. It resumes in the same cycle `out_ready` returns high.
- Simultaneous pop and returning data with buf_level=1 → buf_level stays 1, `head` takes the new word, and no bubble occurs.
- Reset asserted mid-operation → all state clears immediately, including an in-flight read. The FIFO shares `rst` and is cleared at the same time, so no orphan data is returned after reset.
- No combinational path from `fifo_rd_data` to any output.

## Structure
- Shared package `fifo_pkg`:
  - constant FIFO_RD_LAT = 1
  - function clog2_min1 for counter widths; used by both `sync_fifo` and this block.
- Sub-module `stream_skid_buf`: a 2-entry head/tail buffer with a write port, a pop port and a level output. The top level contains the credit check for `fifo_rd_en`, `inflight` tracking and the burst counter.

## Test plan
- Reset, then push 0x01..0x04 into an empty FIFO with out_ready=1 → `out_valid` rises exactly 2 cycles after `fifo_empty` falls; data 0x01..0x04 on consecutive cycles; `out_last` never high (BURST_LEN=16).
- Stream 48 words continuously with out_ready=1, BURST_LEN=16 → 48 consecutive pops; `out_last` on beats 15, 31 and 47 only.
- Stream 8 words, then drop out_ready for 5 cycles on the cycle after a `fifo_rd_en` → buf_level reaches 2; `fifo_rd_en` stays low while stalled; no word lost or duplicated; order preserved.
- Random out_ready (50%) with random FIFO writes over 10k words → output sequence equals input sequence; buf_level ≤ 2 always; `out_data`/`out_last` stable while valid & !ready.
- FIFO runs dry after beat 5 of a burst, then refills → beat_cnt holds at 6; next data resumes at beat 6; `out_last` on beat 15.
- Assert rst with buf_level=2 and a read in flight → all outputs 0 immediately; after release, the first popped word is the first word written after reset.
